icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Miss handler directly downstream of the instruction cache.
- On a cache miss, it issues one line-aligned burst read to the memory-side port.
- Returned beats are streamed in address order into the cache refill port (refill_valid/refill_data).
- The FSM waits for the cache's refill_complete, then releases the fetch stall; it also handles flush-abort and drain of in-flight beats.

Parameters:
- DATA_LENGTH, 32, width of one refill word/beat.
- LINE_SIZE, 64, cache line size in bytes.
- ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).
- Derived (localparam): WORDS = LINE_SIZE/(DATA_LENGTH/8) = 16; OFFS = log2(LINE_SIZE) = 6; CW = log2(WORDS) = 4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  abort the current refill and drain outstanding beats.
- miss_detected  in  1  miss indication from the cache.
- miss_addr  in  ADDR_WIDTH  fetch address that missed.
- refill_valid  out  1  refill word valid to the cache.
- refill_data  out  DATA_LENGTH  refill word to the cache.
- refill_complete  in  1  cache has written the whole line.
- busy  out  1  stall to the fetch stage while a refill is in progress.
- mem_req  out  1  burst request.
- mem_addr  out  ADDR_WIDTH  line-aligned burst address.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  DATA_LENGTH  read beat data.
- refill_error  out  1  sticky watchdog error (tied 0 without the optional feature).

Behaviour:
- Reset (asynchronous): state=IDLE, beat_cnt=0, all outputs 0 (refill_valid, refill_data, busy, mem_req, mem_addr, refill_error).
- States: IDLE, REQ, FILL, WAIT_DONE, DRAIN.
- IDLE:
  - miss_detected=1 and flush=0: latch line_addr = miss_addr with the low OFFS bits cleared; set busy=1, mem_req=1, mem_addr=line_addr; go to REQ.
  - miss_detected while flush=1 is ignored.
- REQ:
  - Hold mem_req and mem_addr stable until mem_gnt=1.
  - In the gnt cycle: go to FILL and deassert mem_req on the next edge.
  - mem_rvalid is not expected before the grant.
- FILL:
  - Each cycle with mem_rvalid=1: refill_valid=1 and refill_data=mem_rdata on the next cycle (1-cycle registered latency); beat_cnt increments.
  - refill_valid is 0 in cycles following no beat.
  - Beats are forwarded in arrival order: beat k maps to line word k.
  - On the WORDS-th beat (beat_cnt == WORDS-1 with rvalid): beat_cnt wraps to 0, go to WAIT_DONE.
- WAIT_DONE:
  - busy stays 1 and refill_valid is 0.
  - refill_complete=1: busy=0 on the next edge, go to IDLE.
  - A new miss is accepted only from IDLE, never in the same cycle as refill_complete.
- flush:
  - In REQ before the grant: drop mem_req, go to IDLE (no beats are outstanding).
  - In REQ with mem_gnt=1 in the same cycle: grant counts; go to DRAIN.
  - In FILL: go to DRAIN; refill_valid is forced 0 from the next cycle (a beat registered in the flush cycle is suppressed).
  - In WAIT_DONE: go to IDLE.
  - busy stays 1 during DRAIN.
- DRAIN:
  - Count the remaining beats without forwarding them.
  - When beat_cnt reaches WORDS total: beat_cnt=0, busy=0, go to IDLE.
  - Additional flushes in DRAIN have no effect.
- busy = 1 in every state except IDLE, registered.
- refill_data holds its last value when refill_valid=0.
- Reset mid-operation (asynchronous): returns to the reset values immediately; the memory side must tolerate the abandoned burst.

Optional Feature:
- Macro: ICACHE_REFILL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ, FILL and DRAIN; it resets on every grant/beat.
  - On reaching TIMEOUT_CYCLES: set refill_error=1 (sticky until rst), drop mem_req, force IDLE, busy=0, refill_valid=0.
- Not defined: no counter is built; refill_error is tied 0; TIMEOUT_CYCLES is unused.

Test Plan:
- Basic refill:
  - Stimulus: miss_addr=0x0000_1234 with miss_detected pulse; mem_gnt after 3 cycles; 16 back-to-back beats with rdata = 0..15; refill_complete 1 cycle after the last refill_valid.
  - Required: mem_addr=0x0000_1200; exactly 16 refill_valid pulses with data 0..15 in order, each 1 cycle after its rvalid; busy falls the cycle after refill_complete.
- Gapped beats:
  - Stimulus: rvalid asserted every other cycle.
  - Required: 16 refill_valid pulses, same gaps, no duplicates; state reaches WAIT_DONE only after beat 16.
- Flush mid-fill:
  - Stimulus: flush during beat 5, remaining 11 beats delivered.
  - Required: no refill_valid after the flush cycle; busy=1 until beat 16 is drained, then 0; no new mem_req during DRAIN.
- Flush before grant:
  - Stimulus: flush in REQ with mem_gnt=0.
  - Required: mem_req=0 and busy=0 the next cycle.
- Miss while busy / reset mid-fill:
  - Stimulus: miss_detected pulses during FILL.
  - Required: ignored (single mem_req).
  - Stimulus: rst asserted at beat 8.
  - Required: all outputs 0 immediately, state IDLE.
- Timeout (macro defined, TIMEOUT_CYCLES=20):
  - Stimulus: grant then no beats.
  - Required: refill_error=1 after 20 cycles; busy=0; refill_error stays 1 across a following successful refill.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
// rtl/icache_refill_ctrl_if.sv - cache-side and memory-side signal bundle for the I-cache refill controller
interface icache_refill_ctrl_if #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_WIDTH  = 32
);
  logic                   flush;
  logic                   miss_detected;
  logic [ADDR_WIDTH-1:0]  miss_addr;
  logic                   refill_valid;
  logic [DATA_LENGTH-1:0] refill_data;
  logic                   refill_complete;
  logic                   busy;
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_gnt;
  logic                   mem_rvalid;
  logic [DATA_LENGTH-1:0] mem_rdata;
  logic                   refill_error;

  modport master (
    input  flush, miss_detected, miss_addr, refill_complete, mem_gnt, mem_rvalid, mem_rdata,
    output refill_valid, refill_data, busy, mem_req, mem_addr, refill_error
  );

  modport slave (
    output flush, miss_detected, miss_addr, refill_complete, mem_gnt, mem_rvalid, mem_rdata,
    input  refill_valid, refill_data, busy, mem_req, mem_addr, refill_error
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - I-cache miss handler: line burst fetch, refill streaming, flush drain
// Optional watchdog enabled by defining ICACHE_REFILL_TIMEOUT_EN.
module icache_refill_ctrl #(
  parameter int DATA_LENGTH    = 32,
  parameter int LINE_SIZE      = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  rst,
  icache_refill_ctrl_if.master bus
);
  localparam int WORDS = LINE_SIZE / (DATA_LENGTH / 8);
  localparam int OFFS  = $clog2(LINE_SIZE);
  localparam int CW    = $clog2(WORDS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(WORDS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REQ       = 3'd1;
  localparam logic [2:0] FILL      = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] DRAIN     = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] beat_cnt;
  logic          timeout;
  logic          unused_offs;

  assign unused_offs = ^bus.miss_addr[OFFS-1:0];

`ifdef ICACHE_REFILL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_active;
  logic          progress;

  // Any grant or beat proves the memory side is alive and restarts the window.
  assign wd_active = (state == REQ) || (state == FILL) || (state == DRAIN);
  assign progress  = ((state == REQ) && bus.mem_gnt) ||
                     (((state == FILL) || (state == DRAIN)) && bus.mem_rvalid);
  assign timeout   = wd_active && !progress && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt           <= '0;
      bus.refill_error <= 1'b0;
    end else begin
      if (!wd_active || progress || timeout)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;
      if (timeout)
        bus.refill_error <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout   = (TIMEOUT_CYCLES != 0);
  assign timeout          = 1'b0;
  assign bus.refill_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      bus.refill_valid <= 1'b0;
      bus.refill_data  <= '0;
      bus.busy         <= 1'b0;
      bus.mem_req      <= 1'b0;
      bus.mem_addr     <= '0;
    end else begin
      bus.refill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.miss_detected && !bus.flush) begin
            bus.mem_addr <= {bus.miss_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
            bus.mem_req  <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          // A grant wins over a simultaneous flush: the burst is then outstanding.
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            state       <= bus.flush ? DRAIN : FILL;
          end else if (bus.flush) begin
            bus.mem_req <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        FILL: begin
          if (bus.mem_rvalid) begin
            if (!bus.flush) begin
              bus.refill_valid <= 1'b1;
              bus.refill_data  <= bus.mem_rdata;
            end
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              if (bus.flush) begin
                bus.busy <= 1'b0;
                state    <= IDLE;
              end else begin
                state <= WAIT_DONE;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              if (bus.flush)
                state <= DRAIN;
            end
          end else if (bus.flush) begin
            state <= DRAIN;
          end
        end
        WAIT_DONE: begin
          if (bus.flush || bus.refill_complete) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.mem_rvalid) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              bus.busy <= 1'b0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
          bus.busy <= 1'b0;
        end
      endcase

      if (timeout) begin
        state            <= IDLE;
        beat_cnt         <= '0;
        bus.busy         <= 1'b0;
        bus.mem_req      <= 1'b0;
        bus.refill_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  icache_refill_ctrl_if #(.DATA_LENGTH(32), .ADDR_WIDTH(32)) bus ();

  icache_refill_ctrl #(
    .DATA_LENGTH(32), .LINE_SIZE(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_miss(input logic [31:0] addr, input logic [31:0] line);
    bus.miss_detected = 1'b1;
    bus.miss_addr     = addr;
    tick();
    bus.miss_detected = 1'b0;
    chk("miss_busy", {63'd0, bus.busy}, 64'd1);
    chk("miss_req", {63'd0, bus.mem_req}, 64'd1);
    chk("miss_addr", {32'd0, bus.mem_addr}, {32'd0, line});
  endtask

  task automatic grant();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    chk("gnt_req_drop", {63'd0, bus.mem_req}, 64'd0);
  endtask

  task automatic beat(input logic [31:0] d, input logic exp_v);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = d;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("beat_valid", {63'd0, bus.refill_valid}, {63'd0, exp_v});
    if (exp_v)
      chk("beat_data", {32'd0, bus.refill_data}, {32'd0, d});
  endtask

  task automatic complete_line();
    bus.refill_complete = 1'b1;
    tick();
    bus.refill_complete = 1'b0;
    chk("done_busy", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.miss_detected = 1'b0; bus.miss_addr = '0;
    bus.refill_complete = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    chk("rst_valid", {63'd0, bus.refill_valid}, 64'd0);
    chk("rst_data", {32'd0, bus.refill_data}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_req", {63'd0, bus.mem_req}, 64'd0);
    chk("rst_addr", {32'd0, bus.mem_addr}, 64'd0);
    chk("rst_err", {63'd0, bus.refill_error}, 64'd0);
    rst = 1'b0;
    tick();

    // Basic refill: grant after 3 cycles, 16 back-to-back beats
    start_miss(32'h0000_1234, 32'h0000_1200);
    tick(); tick();
    chk("req_hold", {63'd0, bus.mem_req}, 64'd1);
    chk("req_addr_hold", {32'd0, bus.mem_addr}, 64'h1200);
    grant();
    for (int k = 0; k < 16; k++) beat(32'(k), 1'b1);
    tick();
    chk("wait_valid", {63'd0, bus.refill_valid}, 64'd0);
    chk("wait_busy", {63'd0, bus.busy}, 64'd1);
    chk("wait_data_hold", {32'd0, bus.refill_data}, 64'd15);
    // Miss coinciding with refill_complete is not taken; it is on the next cycle
    bus.miss_detected = 1'b1;
    bus.miss_addr     = 32'h0000_0080;
    complete_line();
    chk("no_same_cycle_miss", {63'd0, bus.mem_req}, 64'd0);
    tick();
    bus.miss_detected = 1'b0;
    chk("next_miss_req", {63'd0, bus.mem_req}, 64'd1);
    chk("next_miss_addr", {32'd0, bus.mem_addr}, 64'h80);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);

    // Gapped beats: every other cycle; refill_complete during FILL has no effect
    start_miss(32'h0000_ABCD, 32'h0000_ABC0);
    grant();
    for (int k = 0; k < 16; k++) begin
      beat(32'h100 + 32'(k), 1'b1);
      if (k == 14) bus.refill_complete = 1'b1;
      tick();
      bus.refill_complete = 1'b0;
      chk("gap_valid", {63'd0, bus.refill_valid}, 64'd0);
      chk("gap_data_hold", {32'd0, bus.refill_data}, {32'd0, 32'h100 + 32'(k)});
      chk("gap_busy", {63'd0, bus.busy}, 64'd1);
    end
    complete_line();

    // Flush during beat 5, remaining 11 beats drained with no forwarding
    start_miss(32'h2000_0040, 32'h2000_0040);
    tick();
    grant();
    for (int k = 0; k < 4; k++) beat(32'hA0 + 32'(k), 1'b1);
    bus.flush = 1'b1;
    beat(32'hA4, 1'b0);
    bus.flush = 1'b0;
    chk("flush_data_hold", {32'd0, bus.refill_data}, 64'hA3);
    for (int k = 5; k < 16; k++) begin
      if (k == 8) bus.flush = 1'b1;
      beat(32'hA0 + 32'(k), 1'b0);
      bus.flush = 1'b0;
      chk("drain_busy", {63'd0, bus.busy}, (k == 15) ? 64'd0 : 64'd1);
      chk("drain_req", {63'd0, bus.mem_req}, 64'd0);
    end
    tick();
    chk("post_drain_busy", {63'd0, bus.busy}, 64'd0);

    // Flush before grant; then a miss under flush in IDLE is ignored
    start_miss(32'h0000_0047, 32'h0000_0040);
    bus.flush = 1'b1;
    tick();
    chk("pre_gnt_flush_req", {63'd0, bus.mem_req}, 64'd0);
    chk("pre_gnt_flush_busy", {63'd0, bus.busy}, 64'd0);
    bus.miss_detected = 1'b1;
    tick();
    bus.miss_detected = 1'b0;
    bus.flush = 1'b0;
    chk("flush_miss_busy", {63'd0, bus.busy}, 64'd0);
    chk("flush_miss_req", {63'd0, bus.mem_req}, 64'd0);

    // Misses during FILL ignored, then async reset at beat 8
    start_miss(32'h0000_3000, 32'h0000_3000);
    grant();
    for (int k = 0; k < 8; k++) begin
      bus.miss_detected = (k >= 2 && k <= 4);
      bus.miss_addr     = 32'hFFFF_FFFF;
      beat(32'h300 + 32'(k), 1'b1);
      chk("busy_miss_req", {63'd0, bus.mem_req}, 64'd0);
      chk("busy_miss_addr", {32'd0, bus.mem_addr}, 64'h3000);
    end
    bus.miss_detected = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, bus.refill_valid}, 64'd0);
    chk("arst_data", {32'd0, bus.refill_data}, 64'd0);
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_req", {63'd0, bus.mem_req}, 64'd0);
    chk("arst_addr", {32'd0, bus.mem_addr}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    // Fresh refill after reset needs the full 16 beats
    start_miss(32'h0000_5010, 32'h0000_5000);
    grant();
    for (int k = 0; k < 16; k++) beat(32'h500 + 32'(k), 1'b1);
    complete_line();

`ifdef ICACHE_REFILL_TIMEOUT_EN
    start_miss(32'h0000_6000, 32'h0000_6000);
    grant();
    repeat (19) tick();
    chk("to_pre_busy", {63'd0, bus.busy}, 64'd1);
    chk("to_pre_err", {63'd0, bus.refill_error}, 64'd0);
    tick();
    chk("to_err", {63'd0, bus.refill_error}, 64'd1);
    chk("to_busy", {63'd0, bus.busy}, 64'd0);
    chk("to_req", {63'd0, bus.mem_req}, 64'd0);
    start_miss(32'h0000_7000, 32'h0000_7000);
    grant();
    for (int k = 0; k < 16; k++) beat(32'h700 + 32'(k), 1'b1);
    complete_line();
    chk("to_sticky", {63'd0, bus.refill_error}, 64'd1);
`else
    chk("err_tied", {63'd0, bus.refill_error}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
